// File: rtl/led_pwm_bank_pkg.sv
// led_pwm_bank_pkg: shared constants, command codes and FSM encoding for the
// LED PWM bank that sits behind the SPI frame decoder.
package led_pwm_bank_pkg;

  localparam int NUM_LEDS         = 8;
  localparam int PAYLOAD_BITS     = 8;
  localparam int ADDR_BITS        = 8;
  localparam int BRIGHTNESS_WIDTH = PAYLOAD_BITS - 1;
  localparam int PRESCALE_DEFAULT = 4;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_LED_SET  = 8'h01;
  localparam logic [7:0] CMD_LED_READ = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Brightness travels in the upper bits of a byte, bit 0 is padding.
  function automatic logic [PAYLOAD_BITS-1:0] pack_brightness(
    input logic [BRIGHTNESS_WIDTH-1:0] b
  );
    return {b, 1'b0};
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// led_pwm_bank_if: decoded-word command channel between the SPI frame decoder
// (master) and the LED bank (slave), plus the read/error return path.
interface led_pwm_bank_if;
  import led_pwm_bank_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [PAYLOAD_BITS-1:0] cmd;
  logic [ADDR_BITS-1:0]    addr;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    rd_valid;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic                    cmd_err;

  modport master (
    output cmd_valid, cmd, addr, payload,
    input  cmd_ready, rd_valid, rd_data, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, addr, payload,
    output cmd_ready, rd_valid, rd_data, cmd_err
  );

endinterface

// File: rtl/led_pwm_bank_pwm_timebase.sv
// pwm_timebase: prescaler plus PWM step counter shared by every LED channel.
// pwm_cnt runs 0..2^CNT_BITS-2; period_start is high in the cycle whose
// clock edge returns the counter to 0.
module pwm_timebase #(
  parameter int PRESCALE = 4,
  parameter int CNT_BITS = 7
) (
  input  logic                sysclk,
  input  logic                rst_n,
  output logic [CNT_BITS-1:0] pwm_cnt,
  output logic                period_start
);

  localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = {{(CNT_BITS-1){1'b1}}, 1'b0};

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                step_s;

  assign step_s       = (presc_q == PS_LAST);
  assign period_start = step_s && (cnt_q == CNT_LAST);
  assign pwm_cnt      = cnt_q;

  // Next prescaler and step count: the step counter only moves on prescaler wrap.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (step_s) begin
      presc_d = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  // Timebase state registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: per-LED brightness registers written/read by decoded SPI
// words, driving glitch-free PWM on the led pins. Duty only changes at a
// period boundary. Optional macro LED_FADE_EN makes the active duty step one
// LSB per period toward the target instead of jumping.
module led_pwm_bank #(
  parameter int NUM_LEDS = led_pwm_bank_pkg::NUM_LEDS,
  parameter int PWM_BITS = led_pwm_bank_pkg::BRIGHTNESS_WIDTH,
  parameter int PRESCALE = led_pwm_bank_pkg::PRESCALE_DEFAULT
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  led_pwm_bank_if.slave        bus,
  output logic [NUM_LEDS-1:0]  led
);
  import led_pwm_bank_pkg::*;

  localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(NUM_LEDS);

  state_e                              state_q, state_d;
  logic                                cmd_ready_q, cmd_ready_d;
  logic [PAYLOAD_BITS-1:0]             cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]                addr_q, addr_d;
  logic [PWM_BITS-1:0]                 bright_q, bright_d;
  logic                                rd_valid_q, rd_valid_d;
  logic [PAYLOAD_BITS-1:0]             rd_data_q, rd_data_d;
  logic                                cmd_err_q, cmd_err_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]   target_q, target_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]   active_q, active_d;
  logic [NUM_LEDS-1:0]                 led_q, led_d;
  logic [PWM_BITS-1:0]                 pwm_cnt;
  logic                                period_start;
  logic                                addr_ok_s;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .CNT_BITS (PWM_BITS)
  ) u_timebase (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start)
  );

  assign addr_ok_s     = (addr_q < ADDR_LIMIT);
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.cmd_err   = cmd_err_q;
  assign led           = led_q;

  // Command FSM: latch a word in IDLE, act on it in EXEC, pulse results in RESP.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    bright_d   = bright_q;
    rd_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    rd_data_d  = rd_data_q;
    target_d   = target_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_d    = bus.cmd;
          addr_d   = bus.addr;
          bright_d = bus.payload[PWM_BITS:1];
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        case (cmd_q)
          CMD_NOP: begin
            cmd_err_d = 1'b0;
          end
          CMD_LED_SET: begin
            if (addr_ok_s) begin
              for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr_q == ADDR_BITS'(i)) begin
                  target_d[i] = bright_q;
                end else begin
                  target_d[i] = target_q[i];
                end
              end
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          CMD_LED_READ: begin
            if (addr_ok_s) begin
              rd_valid_d = 1'b1;
              for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr_q == ADDR_BITS'(i)) begin
                  rd_data_d = pack_brightness(target_q[i]);
                end else begin
                  rd_data_d = rd_data_d;
                end
              end
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          default: begin
            cmd_err_d = 1'b1;
          end
        endcase
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Duty update at the period boundary and registered PWM comparators.
  always_comb begin
    active_d = active_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (period_start) begin
`ifdef LED_FADE_EN
        if (active_q[i] < target_q[i]) begin
          active_d[i] = active_q[i] + PWM_BITS'(1);
        end else if (active_q[i] > target_q[i]) begin
          active_d[i] = active_q[i] - PWM_BITS'(1);
        end else begin
          active_d[i] = active_q[i];
        end
`else
        active_d[i] = target_q[i];
`endif
      end else begin
        active_d[i] = active_q[i];
      end
      led_d[i] = (pwm_cnt < active_q[i]);
    end
  end

  // State, command and PWM registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      cmd_q       <= '0;
      addr_q      <= '0;
      bright_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cmd_err_q   <= 1'b0;
      target_q    <= '0;
      active_q    <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bright_q    <= bright_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cmd_err_q   <= cmd_err_d;
      target_q    <= target_d;
      active_q    <= active_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: randomized self-checking bench. The reference model holds
// the target brightness per LED and predicts, per full PWM period, how many
// cycles each LED is lit (brightness * PRESCALE).
module tb_led_pwm_bank;
  import led_pwm_bank_pkg::*;

  localparam int P      = 4;
  localparam int PERIOD = 127 * P;

  logic                sysclk = 1'b0;
  logic                rst_n  = 1'b0;
  logic [NUM_LEDS-1:0] led;

  led_pwm_bank_if bus();

  led_pwm_bank #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (7),
    .PRESCALE (P)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .led    (led)
  );

  always #4 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_tgt [NUM_LEDS];
  int shown     [NUM_LEDS];
  int meas      [NUM_LEDS];

  // observations from the last word sent
  int         rd_at, rd_cnt, err_at, err_cnt;
  logic [7:0] rd_seen;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Model update from the specification's rules.
  function automatic void model_word(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    if (c == CMD_LED_SET && a < 8'(NUM_LEDS)) model_tgt[a] = int'(p[7:1]);
  endfunction

  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    @(negedge sysclk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_before_send: got %b want 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.addr = a; bus.payload = p;
    @(negedge sysclk);
    bus.cmd_valid = 1'b0;
    model_word(c, a, p);
    rd_at = -1; rd_cnt = 0; err_at = -1; err_cnt = 0; rd_seen = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      if (bus.rd_valid === 1'b1) begin
        rd_cnt++; rd_seen = bus.rd_data;
        if (rd_at < 0) rd_at = k;
      end
      if (bus.cmd_err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (k < 5) @(negedge sysclk);
    end
  endtask

  task automatic settle_and_measure();
    int extra = 0;
`ifdef LED_FADE_EN
    for (int i = 0; i < NUM_LEDS; i++) begin
      int d = (model_tgt[i] > shown[i]) ? model_tgt[i] - shown[i] : shown[i] - model_tgt[i];
      if (d > extra) extra = d;
    end
`endif
    repeat ((2 + extra) * PERIOD) @(negedge sysclk);
    for (int i = 0; i < NUM_LEDS; i++) meas[i] = 0;
    for (int t = 0; t < PERIOD; t++) begin
      @(negedge sysclk);
      for (int i = 0; i < NUM_LEDS; i++) if (led[i] === 1'b1) meas[i]++;
    end
    for (int i = 0; i < NUM_LEDS; i++) shown[i] = model_tgt[i];
  endtask

  task automatic test_reset();
    int bad = 0;
    bus.cmd_valid = 1'b0; bus.cmd = 8'h00; bus.addr = 8'h00; bus.payload = 8'h00;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin model_tgt[i] = 0; shown[i] = 0; end
    repeat (3) @(negedge sysclk);
    n_checks += 5;
    if (led !== '0)            begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    if (bus.rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    if (bus.rd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    if (bus.cmd_err !== 1'b0)   begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", bus.cmd_err); end
    rst_n = 1'b1;
    for (int t = 0; t < 2 * PERIOD; t++) begin
      @(negedge sysclk);
      if (led !== '0 || bus.rd_valid !== 1'b0 || bus.cmd_err !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_idle_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_checks++;
      if (meas[i] != model_tgt[i] * P) begin
        n_fail++;
        $display("FAIL %s_led%0d_on_cycles: got %0d want %0d", tag, i, meas[i], model_tgt[i] * P);
      end
    end
  endtask

  task automatic test_set_basic();
    send(CMD_LED_SET, 8'd0, 8'h14);
    n_checks += 2;
    if (rd_cnt != 0)  begin n_fail++; $display("FAIL set_no_rd: got %0d want 0", rd_cnt); end
    if (err_cnt != 0) begin n_fail++; $display("FAIL set_no_err: got %0d want 0", err_cnt); end
    settle_and_measure();
    check_counts("set_basic");
  endtask

  task automatic test_extremes();
    send(CMD_LED_SET, 8'd7, 8'hFE);
    send(CMD_LED_SET, 8'd3, 8'h00);
    settle_and_measure();
    check_counts("extremes");
  endtask

  task automatic test_errors();
    send(CMD_LED_SET, 8'h10, 8'hFF);
    n_checks += 3;
    if (err_cnt != 1) begin n_fail++; $display("FAIL bad_addr_err_count: got %0d want 1", err_cnt); end
    if (err_at != 2)  begin n_fail++; $display("FAIL bad_addr_err_latency: got %0d want 2", err_at); end
    if (rd_cnt != 0)  begin n_fail++; $display("FAIL bad_addr_no_rd: got %0d want 0", rd_cnt); end
    send(8'h55, 8'd1, 8'h80);
    n_checks++;
    if (err_cnt != 1) begin n_fail++; $display("FAIL bad_cmd_err_count: got %0d want 1", err_cnt); end
    send(CMD_NOP, 8'd2, 8'hAA);
    n_checks++;
    if (err_cnt != 0 || rd_cnt != 0) begin
      n_fail++; $display("FAIL nop_quiet: got err=%0d rd=%0d want 0 0", err_cnt, rd_cnt);
    end
    for (int i = 0; i < NUM_LEDS; i++) begin
      send(CMD_LED_READ, 8'(i), 8'h00);
      n_checks++;
      if (rd_cnt != 1 || rd_seen !== {7'(model_tgt[i]), 1'b0}) begin
        n_fail++;
        $display("FAIL errors_readback%0d: got cnt=%0d data=%h want 1 %h", i, rd_cnt, rd_seen, {7'(model_tgt[i]), 1'b0});
      end
    end
  endtask

  task automatic test_read();
    send(CMD_LED_SET, 8'd7, 8'h02);
    send(CMD_LED_READ, 8'd7, 8'h00);
    n_checks += 4;
    if (rd_cnt != 1)      begin n_fail++; $display("FAIL read_pulse_count: got %0d want 1", rd_cnt); end
    if (rd_at != 2)       begin n_fail++; $display("FAIL read_latency: got %0d want 2", rd_at); end
    if (rd_seen !== 8'h02) begin n_fail++; $display("FAIL read_data: got %h want 02", rd_seen); end
    if (err_cnt != 0)     begin n_fail++; $display("FAIL read_no_err: got %0d want 0", err_cnt); end
    send(CMD_LED_READ, 8'd9, 8'h00);
    n_checks += 2;
    if (rd_cnt != 0 || err_cnt != 1) begin
      n_fail++; $display("FAIL read_bad_addr: got rd=%0d err=%0d want 0 1", rd_cnt, err_cnt);
    end
    if (bus.rd_data !== 8'h02) begin n_fail++; $display("FAIL read_data_hold: got %h want 02", bus.rd_data); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        logic [6:0] b;
        logic       pad;
        b   = 7'($urandom_range(0, 127));
        pad = 1'($urandom_range(0, 1));
        send(CMD_LED_SET, 8'(i), {b, pad});
      end
      begin
        int a = $urandom_range(0, NUM_LEDS - 1);
        send(CMD_LED_READ, 8'(a), 8'h00);
        n_checks++;
        if (rd_seen !== {7'(model_tgt[a]), 1'b0}) begin
          n_fail++; $display("FAIL random_read%0d: got %h want %h", a, rd_seen, {7'(model_tgt[a]), 1'b0});
        end
      end
      settle_and_measure();
      check_counts("random");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge sysclk);
    bus.cmd_valid = 1'b1; bus.cmd = CMD_LED_SET; bus.addr = 8'd5; bus.payload = 8'h40;
    @(negedge sysclk);
    model_word(CMD_LED_SET, 8'd5, 8'h40);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", bus.cmd_ready); end
    bus.payload = 8'h7E;  // second word while busy: dropped
    @(negedge sysclk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    send(CMD_LED_READ, 8'd5, 8'h00);
    n_checks++;
    if (rd_seen !== 8'h40) begin n_fail++; $display("FAIL busy_word_dropped: got %h want 40", rd_seen); end
  endtask

  task automatic test_reset_mid();
    send(CMD_LED_SET, 8'd0, 8'hFE);
    settle_and_measure();
    @(negedge sysclk);
    #1;
    n_checks++;
    if (led[0] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre_led0: got %b want 1", led[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== '0) begin n_fail++; $display("FAIL mid_reset_async_led: got %h want 00", led); end
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin model_tgt[i] = 0; shown[i] = 0; end
    send(CMD_LED_READ, 8'd0, 8'h00);
    n_checks++;
    if (rd_seen !== 8'h00) begin n_fail++; $display("FAIL mid_reset_target_cleared: got %h want 00", rd_seen); end
    send(CMD_LED_SET, 8'd2, 8'h0A);
    settle_and_measure();
    check_counts("after_reset");
  endtask

  initial begin
    test_reset();
    test_set_basic();
    test_extremes();
    test_errors();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
